// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined two's-complement adder/subtractor.
// A WIDTH-bit operation is split into STAGES carry-ripple slices of
// SW = WIDTH/STAGES bits. Each pipeline stage computes one slice, so the block
// accepts one operation per clock. A valid/ready handshake gives backpressure.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operation presented on a, b, cin, sub
//   in_ready   operation accepted this cycle (needs advance and rst_n)
//   a, b       WIDTH-bit operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: a + b + cin, 1: a - b - cin
//   out_valid  sum/cout/ovf hold a valid result
//   out_ready  consumer accepts the result
//   sum        result modulo 2^WIDTH
//   cout       raw carry out of the MSB (sub: 1 = no borrow)
//   ovf        signed overflow
module pipe_addsub #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int SW   = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   // Stage registers: stage k holds slices 0..k of the sum, the carry out of
   // slice k, and the operands still needed by later slices.
   logic [WIDTH-1:0] a_q  [STAGES];
   logic [WIDTH-1:0] bx_q [STAGES];
   logic [WIDTH-1:0] s_q  [STAGES];
   logic             c_q  [STAGES];
   logic             v_q  [STAGES];
   logic             ovf_q;

   // Inputs seen by each stage's slice adder (ports for stage 0).
   logic [WIDTH-1:0] src_a  [STAGES];
   logic [WIDTH-1:0] src_bx [STAGES];
   logic [WIDTH-1:0] src_s  [STAGES];
   logic             src_c  [STAGES];
   logic             src_v  [STAGES];
   logic [SW:0]      slice_r [STAGES];

   logic advance;
   logic ovf_nxt;
   logic unused_ops;

   // Whole-pipeline stall: everything moves only when the output slot frees.
   assign advance  = !v_q[LAST] || out_ready;
   assign in_ready = advance && rst_n;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_in
         // Subtract is a + ~b + ~cin; cin ^ sub folds the carry select.
         assign src_a[0]  = a;
         assign src_bx[0] = sub ? ~b : b;
         assign src_s[0]  = '0;
         assign src_c[0]  = cin ^ sub;
         assign src_v[0]  = in_valid;
      end else begin : g_fwd
         assign src_a[k]  = a_q[k-1];
         assign src_bx[k] = bx_q[k-1];
         assign src_s[k]  = s_q[k-1];
         assign src_c[k]  = c_q[k-1];
         assign src_v[k]  = v_q[k-1];
      end

      assign slice_r[k] = {1'b0, src_a[k][k*SW +: SW]}
                        + {1'b0, src_bx[k][k*SW +: SW]}
                        + {{SW{1'b0}}, src_c[k]};
   end

   // Carry into the MSB is recovered as a ^ bx ^ sum at that bit.
   assign ovf_nxt = src_a[LAST][WIDTH-1] ^ src_bx[LAST][WIDTH-1]
                  ^ slice_r[LAST][SW-1] ^ slice_r[LAST][SW];

   // Final-stage operand copies are never read; synthesis prunes them.
   assign unused_ops = ^{a_q[LAST], bx_q[LAST]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            a_q[k]  <= '0;
            bx_q[k] <= '0;
            s_q[k]  <= '0;
            c_q[k]  <= 1'b0;
            v_q[k]  <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (advance) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            a_q[k]  <= src_a[k];
            bx_q[k] <= src_bx[k];
            // Completed slices pass through; only slice k is replaced.
            s_q[k]  <= src_s[k];
            s_q[k][k*SW +: SW] <= slice_r[k][SW-1:0];
            c_q[k]  <= slice_r[k][SW];
            v_q[k]  <= src_v[k];
         end
         ovf_q <= ovf_nxt;
      end
   end

   assign out_valid = v_q[LAST];
   assign sum       = s_q[LAST];
   assign cout      = c_q[LAST];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Testbench for pipe_addsub: scoreboard-checked directed vectors on a 16/4
// instance, plus independent (4,1), (4,4) and (32,8) instances with their own
// reference model and latency check.
module tb_pipe_addsub;

   logic        clk = 1'b0;
   logic        rst_n, rst_sw_n;
   logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [15:0] a, b, sum;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pipe_addsub #(.WIDTH(16), .STAGES(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
   );

   typedef struct packed {
      logic [15:0] a, b;
      logic        cin, sub;
      logic [15:0] s;
      logic        c, o;
   } vec_t;
   typedef struct packed {
      logic [15:0] s;
      logic        c, o;
   } exp_t;

   vec_t vq[$];
   exp_t exp_q[$];

   function automatic vec_t mk(input logic [15:0] va, vb, input logic vc, vs,
                               input logic [15:0] es, input logic ec, eo);
      vec_t v;
      v.a = va; v.b = vb; v.cin = vc; v.sub = vs; v.s = es; v.c = ec; v.o = eo;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", nm, act, req);
      end
   endtask

   // Feed all queued vectors, one attempt per cycle; optionally hold
   // out_ready low for 3 cycles once the first result shows up.
   task automatic run_vecs(input bit do_stall);
      int unsigned stall_left = 0;
      bit          armed = do_stall;
      int unsigned guard = 0;
      while (vq.size() != 0 && guard < 200) begin
         @(negedge clk);
         guard++;
         if (armed && out_valid) begin
            stall_left = 3;
            armed = 1'b0;
         end
         out_ready = (stall_left == 0);
         if (stall_left != 0) stall_left--;
         in_valid = 1'b1;
         a = vq[0].a; b = vq[0].b; cin = vq[0].cin; sub = vq[0].sub;
         #1;
         if (!out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
         if (in_ready) begin
            exp_q.push_back('{s: vq[0].s, c: vq[0].c, o: vq[0].o});
            void'(vq.pop_front());
         end
      end
      checks++;
      if (vq.size() != 0) begin
         errors++;
         $display("FAIL issue_timeout: got %0d vectors left required 0", vq.size());
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   // Main scoreboard monitor: any valid output must match the queue head.
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL main_spurious: got sum=%h cout=%b ovf=%b required no output",
                        sum, cout, ovf);
            end else begin
               if ({sum, cout, ovf} !== {exp_q[0].s, exp_q[0].c, exp_q[0].o}) begin
                  errors++;
                  $display("FAIL main_result: got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                           sum, cout, ovf, exp_q[0].s, exp_q[0].c, exp_q[0].o);
               end
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      rst_sw_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_sw_n = 1'b1;
   end

   // Parameter sweep instances, each with its own model and latency check.
   for (genvar g = 0; g < 3; g++) begin : sw
      localparam int W    = (g == 2) ? 32 : 4;
      localparam int S    = (g == 0) ? 1 : (g == 1) ? 4 : 8;
      localparam int NOPS = (W == 4) ? 1024 : 300;

      logic [W-1:0] sa, sb, ssum, va, vb, bx, es;
      logic         scin, ssub, sin_valid, sin_ready, sout_valid, scout, sovf;
      logic         vc, vs, ec, eo;
      logic [W:0]   full;
      logic [31:0]  ti;
      int unsigned  et;
      logic         done_f = 1'b0;
      logic [W-1:0] qs[$];
      logic         qc[$];
      logic         qo[$];
      int unsigned  qt[$];

      pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
         .clk(clk), .rst_n(rst_sw_n), .in_valid(sin_valid), .in_ready(sin_ready),
         .a(sa), .b(sb), .cin(scin), .sub(ssub), .out_valid(sout_valid),
         .out_ready(1'b1), .sum(ssum), .cout(scout), .ovf(sovf)
      );

      initial begin
         sin_valid = 1'b0; sa = '0; sb = '0; scin = 1'b0; ssub = 1'b0;
         repeat (4) @(negedge clk);
         for (int i = 0; i < NOPS; i++) begin
            @(negedge clk);
            ti = 32'(i);
            if (W == 4) begin
               va = W'(ti[3:0]); vb = W'(ti[7:4]); vc = ti[8]; vs = ti[9];
            end else begin
               va = W'($urandom); vb = W'($urandom);
               vc = 1'($urandom); vs = 1'($urandom);
            end
            sa = va; sb = vb; scin = vc; ssub = vs; sin_valid = 1'b1;
            #1;
            bx   = vs ? ~vb : vb;
            full = {1'b0, va} + {1'b0, bx} + (W+1)'(vs ^ vc);
            checks++;
            if (!sin_ready) begin
               errors++;
               $display("FAIL sweep_W%0d_S%0d_in_ready: got 0 required 1", W, S);
            end else begin
               qs.push_back(full[W-1:0]);
               qc.push_back(full[W]);
               qo.push_back((va[W-1] == bx[W-1]) && (full[W-1] != va[W-1]));
               qt.push_back(cyc + 1);
            end
         end
         @(negedge clk);
         sin_valid = 1'b0;
         for (int j = 0; j < S + 20 && qs.size() != 0; j++) @(negedge clk);
         checks++;
         if (qs.size() != 0) begin
            errors++;
            $display("FAIL sweep_W%0d_S%0d_drain: got %0d pending required 0", W, S, qs.size());
         end
         done_f = 1'b1;
      end

      initial begin
         forever begin
            @(negedge clk);
            #3;
            if (sout_valid) begin
               checks++;
               if (qs.size() == 0) begin
                  errors++;
                  $display("FAIL sweep_W%0d_S%0d_spurious: got sum=%h required no output", W, S, ssum);
               end else begin
                  es = qs.pop_front(); ec = qc.pop_front(); eo = qo.pop_front();
                  et = qt.pop_front();
                  if ({ssum, scout, sovf} !== {es, ec, eo} || cyc != et + S - 1) begin
                     errors++;
                     $display("FAIL sweep_W%0d_S%0d: got sum=%h cout=%b ovf=%b at edge %0d required sum=%h cout=%b ovf=%b at edge %0d",
                              W, S, ssum, scout, sovf, cyc, es, ec, eo, et + S - 1);
                  end
               end
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum",       32'(sum),       32'd0);
      chk("rst_cout",      32'(cout),      32'd0);
      chk("rst_ovf",       32'(ovf),       32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Carry ripples through all four slices.
      vq.push_back(mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
      run_vecs(1'b0);
      drain();
      repeat (5) @(negedge clk);

      // Signed overflow and subtract-with-borrow.
      vq.push_back(mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1));
      vq.push_back(mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1));
      vq.push_back(mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0));
      vq.push_back(mk(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0));
      run_vecs(1'b0);
      drain();

      // Eight back-to-back operations with a 3-cycle output stall.
      vq.push_back(mk(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0));
      vq.push_back(mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0));
      vq.push_back(mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1));
      vq.push_back(mk(16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0));
      vq.push_back(mk(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1));
      vq.push_back(mk(16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0));
      vq.push_back(mk(16'hABCD, 16'h1234, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0));
      vq.push_back(mk(16'h7FFF, 16'h8000, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1));
      run_vecs(1'b1);
      drain();

      // Reset with three operations in flight: none may emerge.
      vq.push_back(mk(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0));
      vq.push_back(mk(16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0));
      vq.push_back(mk(16'h00F0, 16'h000F, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0));
      run_vecs(1'b0);
      rst_n = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_sum",       32'(sum),       32'd0);
      chk("midrst_in_ready",  32'(in_ready),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);

      vq.push_back(mk(16'h0001, 16'h0002, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b0));
      run_vecs(1'b0);
      drain();

      for (int i = 0; i < 3000 && !(sw[0].done_f && sw[1].done_f && sw[2].done_f); i++)
         @(negedge clk);
      chk("sweep_done", 32'({sw[2].done_f, sw[1].done_f, sw[0].done_f}), 32'd7);
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
